// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder: stage 1 builds the transition-minimised q_m word,
// stage 2 applies DC balancing against the running disparity or emits a control token.
module tmds_channel_encoder #(
  parameter logic [9:0] RESET_SYMBOL = 10'b1101010100
) (
  input  logic              pixelClock,
  input  logic              reset,
  input  logic              videoEnable,
  input  logic [7:0]        videoData,
  input  logic [1:0]        controlData,
  output logic [9:0]        tmdsSymbol,
  output logic              symbolValid,
  output logic signed [4:0] disparity
);

  logic       ve_q, ve_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [8:0] qm_q, qm_d;
  logic [9:0] sym_q, sym_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] vld_q, vld_d;

  logic [3:0] n1_in;
  logic       use_xnor;
  logic [3:0] n1q, n0q;
  logic [4:0] diff;
  logic [4:0] two_q8;
  logic [4:0] two_nq8;
  logic       cnt_pos, cnt_neg;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [1:0] p0, p1, p2, p3;
    logic [2:0] s0, s1;
    p0 = {1'b0, v[0]} + {1'b0, v[1]};
    p1 = {1'b0, v[2]} + {1'b0, v[3]};
    p2 = {1'b0, v[4]} + {1'b0, v[5]};
    p3 = {1'b0, v[6]} + {1'b0, v[7]};
    s0 = {1'b0, p0} + {1'b0, p1};
    s1 = {1'b0, p2} + {1'b0, p3};
    return {1'b0, s0} + {1'b0, s1};
  endfunction

  always_comb begin
    ve_d     = videoEnable;
    ctrl_d   = controlData;
    n1_in    = ones8(videoData);
    use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !videoData[0]);
    qm_d     = '0;
    qm_d[0]  = videoData[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ videoData[i]) : (qm_d[i-1] ^ videoData[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  // Disparity terms are all 5-bit two's complement so a single adder width covers -10..+10.
  always_comb begin
    n1q     = ones8(qm_q[7:0]);
    n0q     = 4'd8 - n1q;
    diff    = {1'b0, n1q} - {1'b0, n0q};
    two_q8  = {3'b000, qm_q[8], 1'b0};
    two_nq8 = {3'b000, ~qm_q[8], 1'b0};
    cnt_pos = !cnt_q[4] && (cnt_q != 5'd0);
    cnt_neg = cnt_q[4];
    vld_d   = {vld_q[0], 1'b1};
    sym_d   = RESET_SYMBOL;
    cnt_d   = 5'd0;
    if (!ve_q) begin
      unique case (ctrl_q)
        2'b00:   sym_d = 10'b1101010100;
        2'b01:   sym_d = 10'b0010101011;
        2'b10:   sym_d = 10'b0101010100;
        default: sym_d = 10'b1010101011;
      endcase
    end else if ((cnt_q == 5'd0) || (n1q == n0q)) begin
      sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && (n1q > n0q)) || (cnt_neg && (n0q > n1q))) begin
      sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d = cnt_q + two_q8 - diff;
    end else begin
      sym_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d = cnt_q - two_nq8 + diff;
    end
  end

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      ve_q   <= 1'b0;
      ctrl_q <= 2'b00;
      qm_q   <= '0;
      sym_q  <= RESET_SYMBOL;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      ve_q   <= ve_d;
      ctrl_q <= ctrl_d;
      qm_q   <= qm_d;
      sym_q  <= sym_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign tmdsSymbol  = sym_q;
  assign symbolValid = vld_q[1];
  assign disparity   = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: a behavioural encoder model queues the
// expected symbol/disparity when stimulus is driven; entries are popped as they fall due.
module tb_tmds_channel_encoder;

  localparam logic [9:0] RST_SYM = 10'b1101010100;

  logic              pixelClock;
  logic              reset;
  logic              videoEnable;
  logic [7:0]        videoData;
  logic [1:0]        controlData;
  logic [9:0]        tmdsSymbol;
  logic              symbolValid;
  logic signed [4:0] disparity;

  tmds_channel_encoder #(.RESET_SYMBOL(RST_SYM)) dut (
    .pixelClock (pixelClock),
    .reset      (reset),
    .videoEnable(videoEnable),
    .videoData  (videoData),
    .controlData(controlData),
    .tmdsSymbol (tmdsSymbol),
    .symbolValid(symbolValid),
    .disparity  (disparity)
  );

  initial pixelClock = 1'b0;
  always #5 pixelClock = ~pixelClock;

  typedef struct {
    int         due;
    logic [9:0] sym;
    int         cnt;
    logic       valid;
    logic       ve;
    logic [7:0] vd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ecount   = 0;
  int   m_cnt    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  function automatic int popc(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // Reference encoder; advances m_cnt.
  task automatic model_step(input logic ve, input logic [7:0] vd, input logic [1:0] cd,
                            output logic [9:0] sym);
    logic [8:0] qm;
    int n1, n1q, n0q;
    logic xn;
    if (!ve) begin
      case (cd)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      m_cnt = 0;
      return;
    end
    n1 = popc(vd);
    xn = (n1 > 4) || (n1 == 4 && vd[0] == 1'b0);
    qm[0] = vd[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ vd[i]) : (qm[i-1] ^ vd[i]);
    qm[8] = !xn;
    n1q = popc(qm[7:0]);
    n0q = 8 - n1q;
    if (m_cnt == 0 || n1q == n0q) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      m_cnt = m_cnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      m_cnt = m_cnt + 2 * int'(qm[8]) + (n0q - n1q);
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      m_cnt = m_cnt - 2 * int'(!qm[8]) + (n1q - n0q);
    end
  endtask

  task automatic compare(input exp_t e);
    check("symbol", int'(tmdsSymbol), int'(e.sym));
    check("disparity", int'(disparity), e.cnt);
    check("valid", int'(symbolValid), int'(e.valid));
    check("disp_range", int'(disparity >= -5'sd10 && disparity <= 5'sd10), 1);
    if (e.ve && e.valid) check("decode", int'(decode(tmdsSymbol)), int'(e.vd));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge pixelClock);
    ecount++;
    #1;
    while (sb.size() > 0 && sb[0].due <= ecount) begin
      e = sb.pop_front();
      check("due_edge", e.due, ecount);
      compare(e);
    end
  endtask

  task automatic drive(input logic ve, input logic [7:0] vd, input logic [1:0] cd);
    logic [9:0] s;
    videoEnable = ve; videoData = vd; controlData = cd;
    model_step(ve, vd, cd, s);
    sb.push_back('{ecount + 2, s, m_cnt, 1'b1, ve, vd});
    tick();
  endtask

  // Directed variant: expectation comes from hand-derived constants.
  task automatic drive_exp(input logic ve, input logic [7:0] vd, input logic [1:0] cd,
                           input logic [9:0] sym_exp, input int cnt_exp);
    logic [9:0] s;
    videoEnable = ve; videoData = vd; controlData = cd;
    model_step(ve, vd, cd, s);
    sb.push_back('{ecount + 2, sym_exp, cnt_exp, 1'b1, ve, vd});
    tick();
  endtask

  task automatic do_reset(input int n);
    sb.delete();
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      videoEnable = 1'($urandom_range(0, 1));
      videoData   = 8'($urandom_range(0, 255));
      controlData = 2'($urandom_range(0, 3));
      tick();
      check("rst_symbol", int'(tmdsSymbol), int'(RST_SYM));
      check("rst_disparity", int'(disparity), 0);
      check("rst_valid", int'(symbolValid), 0);
    end
    m_cnt = 0;
    reset = 1'b0;
    // First edge after release still shows the reset fill with valid low.
    sb.push_back('{ecount + 1, RST_SYM, 0, 1'b0, 1'b0, 8'h00});
  endtask

  initial begin
    reset = 1'b1; videoEnable = 1'b0; videoData = 8'h00; controlData = 2'b00;

    do_reset(3);
    drive_exp(1'b0, 8'h5A, 2'b11, 10'b1010101011, 0);
    drive_exp(1'b0, 8'hA5, 2'b00, 10'b1101010100, 0);
    drive_exp(1'b0, 8'h3C, 2'b01, 10'b0010101011, 0);
    drive_exp(1'b0, 8'hC3, 2'b10, 10'b0101010100, 0);

    drive_exp(1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);

    drive_exp(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
    drive_exp(1'b1, 8'h00, 2'b00, 10'b0100000000, -8);
    drive_exp(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
    drive_exp(1'b1, 8'h00, 2'b00, 10'b0100000000, -8);

    do_reset(2);
    drive_exp(1'b1, 8'h00, 2'b00, 10'b0100000000, -8);
    drive_exp(1'b1, 8'h00, 2'b00, 10'b1111111111, 2);
    drive_exp(1'b1, 8'h00, 2'b00, 10'b0100000000, -6);

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset(2);
      drive(1'($urandom_range(0, 9) != 0), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)));
    end

    tick();
    tick();
    check("drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
